// File: rtl/credit_link_tx.sv
// credit_link_tx: credit-based flit link transmitter with a local FIFO and a downstream credit counter
module credit_link_tx #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_CREDITS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [DATA_W-1:0]                  in_data,
    output logic                               in_ready,
    output logic                               valid_o,
    output logic [DATA_W-1:0]                  data_o,
    input  logic                               credit_i,
    output logic [$clog2(NUM_CREDITS+1)-1:0]   credit_cnt_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_cnt_o,
    output logic                               credit_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NUM_CREDITS+1);
    localparam int FW = $clog2(FIFO_DEPTH+1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic              push, send, sat;

    assign in_ready = fifo_cnt_o != FW'(FIFO_DEPTH);
    assign push     = in_valid && in_ready;
    assign send     = (fifo_cnt_o != '0) && (credit_cnt_o != '0);
    assign sat      = credit_i && !send && (credit_cnt_o == CW'(NUM_CREDITS));

    // Flit storage; stale contents are harmless because reset clears the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Pointers, occupancy, output register and credit accounting, all decided on pre-edge state
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_cnt_o   <= '0;
            valid_o      <= 1'b0;
            data_o       <= '0;
            credit_cnt_o <= CW'(NUM_CREDITS);
            credit_err_o <= 1'b0;
        end else begin
            wr_ptr       <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr       <= send ? rd_ptr + 1'b1 : rd_ptr;
            fifo_cnt_o   <= fifo_cnt_o + FW'(push) - FW'(send);
            valid_o      <= send;
            data_o       <= send ? mem[rd_ptr] : data_o;
            credit_cnt_o <= sat ? credit_cnt_o : credit_cnt_o - CW'(send) + CW'(credit_i);
            credit_err_o <= credit_err_o || sat;
        end
    end
endmodule

// File: tb/tb_credit_link_tx.sv
// tb_credit_link_tx: table-driven directed check of credit_link_tx plus a post-reset sequence
module tb_credit_link_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        valid_o;
    logic [15:0] data_o;
    logic        credit_i = 1'b0;
    logic [2:0]  credit_cnt_o;
    logic [2:0]  fifo_cnt_o;
    logic        credit_err_o;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] id;
        logic        ci;
        logic        ev;
        logic [15:0] ed;
        int          ecc;
        int          efc;
        logic        erdy;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    credit_link_tx #(.DATA_W(16), .FIFO_DEPTH(4), .NUM_CREDITS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .valid_o(valid_o), .data_o(data_o), .credit_i(credit_i),
        .credit_cnt_o(credit_cnt_o), .fifo_cnt_o(fifo_cnt_o), .credit_err_o(credit_err_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic iv, logic [15:0] id, logic ci, logic ev,
                                logic [15:0] ed, int ecc, int efc, logic erdy, logic eerr);
        vec_t v;
        v.rst = rst; v.iv = iv; v.id = id; v.ci = ci; v.ev = ev;
        v.ed = ed; v.ecc = ecc; v.efc = efc; v.erdy = erdy; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic step(logic rst, logic iv, logic [15:0] id, logic ci);
        reset = rst; in_valid = iv; in_data = id; credit_i = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(int idx, logic ev, logic [15:0] ed, int ecc, int efc, logic erdy, logic eerr);
        chk("valid_o", idx, int'(valid_o), int'(ev));
        chk("data_o", idx, int'(data_o), int'(ed));
        chk("credit_cnt_o", idx, int'(credit_cnt_o), ecc);
        chk("fifo_cnt_o", idx, int'(fifo_cnt_o), efc);
        chk("in_ready", idx, int'(in_ready), int'(erdy));
        chk("credit_err_o", idx, int'(credit_err_o), int'(eerr));
    endtask

    initial begin
        int seen;
        // reset and idle
        tbl.push_back(mk(1,0,16'h0000,0, 0,16'h0000,4,0,1,0));
        tbl.push_back(mk(0,0,16'h0000,0, 0,16'h0000,4,0,1,0));
        // back-to-back burst consumes all credits
        tbl.push_back(mk(0,1,16'hA001,0, 0,16'h0000,4,1,1,0));
        tbl.push_back(mk(0,1,16'hA002,0, 1,16'hA001,3,1,1,0));
        tbl.push_back(mk(0,1,16'hA003,0, 1,16'hA002,2,1,1,0));
        tbl.push_back(mk(0,1,16'hA004,0, 1,16'hA003,1,1,1,0));
        tbl.push_back(mk(0,0,16'h0000,0, 1,16'hA004,0,0,1,0));
        tbl.push_back(mk(0,0,16'h0000,0, 0,16'hA004,0,0,1,0));
        // fill with no credits, drop a push while full
        tbl.push_back(mk(0,1,16'hB001,0, 0,16'hA004,0,1,1,0));
        tbl.push_back(mk(0,1,16'hB002,0, 0,16'hA004,0,2,1,0));
        tbl.push_back(mk(0,1,16'hB003,0, 0,16'hA004,0,3,1,0));
        tbl.push_back(mk(0,1,16'hB004,0, 0,16'hA004,0,4,0,0));
        tbl.push_back(mk(0,1,16'hB005,0, 0,16'hA004,0,4,0,0));
        // one credit releases exactly one flit, usable only from the next edge
        tbl.push_back(mk(0,0,16'h0000,1, 0,16'hA004,1,4,0,0));
        tbl.push_back(mk(0,0,16'h0000,0, 1,16'hB001,0,3,1,0));
        tbl.push_back(mk(0,0,16'h0000,0, 0,16'hB001,0,3,1,0));
        // credit on the same edge as a send keeps the count
        tbl.push_back(mk(0,0,16'h0000,1, 0,16'hB001,1,3,1,0));
        tbl.push_back(mk(0,0,16'h0000,1, 1,16'hB002,1,2,1,0));
        tbl.push_back(mk(0,0,16'h0000,0, 1,16'hB003,0,1,1,0));
        tbl.push_back(mk(0,0,16'h0000,0, 0,16'hB003,0,1,1,0));
        tbl.push_back(mk(0,0,16'h0000,1, 0,16'hB003,1,1,1,0));
        tbl.push_back(mk(0,0,16'h0000,0, 1,16'hB004,0,0,1,0));
        // refill credits, then overflow one
        tbl.push_back(mk(0,0,16'h0000,1, 0,16'hB004,1,0,1,0));
        tbl.push_back(mk(0,0,16'h0000,1, 0,16'hB004,2,0,1,0));
        tbl.push_back(mk(0,0,16'h0000,1, 0,16'hB004,3,0,1,0));
        tbl.push_back(mk(0,0,16'h0000,1, 0,16'hB004,4,0,1,0));
        tbl.push_back(mk(0,0,16'h0000,1, 0,16'hB004,4,0,1,1));
        tbl.push_back(mk(0,0,16'h0000,0, 0,16'hB004,4,0,1,1));
        tbl.push_back(mk(0,1,16'hC001,0, 0,16'hB004,4,1,1,1));
        tbl.push_back(mk(0,0,16'h0000,0, 1,16'hC001,3,0,1,1));
        // build up buffered flits with credits outstanding
        tbl.push_back(mk(0,1,16'hC002,0, 0,16'hC001,3,1,1,1));
        tbl.push_back(mk(0,1,16'hC003,0, 1,16'hC002,2,1,1,1));
        tbl.push_back(mk(0,1,16'hC004,0, 1,16'hC003,1,1,1,1));
        tbl.push_back(mk(0,1,16'hC005,0, 1,16'hC004,0,1,1,1));
        tbl.push_back(mk(0,1,16'hC006,0, 0,16'hC004,0,2,1,1));
        tbl.push_back(mk(0,1,16'hC007,0, 0,16'hC004,0,3,1,1));
        tbl.push_back(mk(0,0,16'h0000,1, 0,16'hC004,1,3,1,1));
        // mid-operation reset ignores push and credit_i
        tbl.push_back(mk(1,1,16'hEEEE,1, 0,16'h0000,4,0,1,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].iv, tbl[i].id, tbl[i].ci);
            check_all(i, tbl[i].ev, tbl[i].ed, tbl[i].ecc, tbl[i].efc, tbl[i].erdy, tbl[i].eerr);
        end

        // no stale flits leak out after reset
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 16'h0000, 0);
            chk("post_reset_valid", i, int'(valid_o), 0);
            chk("post_reset_fifo_cnt", i, int'(fifo_cnt_o), 0);
        end

        // a fresh flit leaves one cycle after its push
        step(0, 1, 16'hD001, 0);
        chk("push_valid_same_cycle", 0, int'(valid_o), 0);
        seen = 0;
        for (int i = 0; i < 4 && seen == 0; i++) begin
            step(0, 0, 16'h0000, 0);
            if (valid_o) seen = i + 1;
        end
        chk("d001_latency", 0, seen, 1);
        chk("d001_data", 0, int'(data_o), 16'hD001);
        chk("d001_credit_cnt", 0, int'(credit_cnt_o), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
